load_store_unit: RTL

//  Memory-access stage directly downstream of the ALU. Takes the ALU result as the effective address.

---
 rtl/load_store_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage running one valid/ready data-memory transaction per load/store
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_data,
    output logic [31:0] load_data,
    output logic        done,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_error
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] f3_q;
    logic [1:0] a_q;
    logic req, f3_ok, aligned;
    logic [3:0] be_in;
    logic [31:0] wdata_in, b_word, h_word, ext;
    always_comb begin
        req = mem_read | mem_write;
        f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (!mem_write && ((funct3 == 3'b100) || (funct3 == 3'b101)));
        aligned = (funct3[1:0] == 2'b01) ? !address[0] :
                  (funct3[1:0] == 2'b10) ? (address[1:0] == 2'b00) : 1'b1;
        be_in = (funct3[1:0] == 2'b00) ? 4'b0001 << address[1:0] :
                (funct3[1:0] == 2'b01) ? 4'b0011 << address[1:0] : 4'hF;
        wdata_in = (funct3[1:0] == 2'b00) ? {4{store_data[7:0]}} :
                   (funct3[1:0] == 2'b01) ? {2{store_data[15:0]}} : store_data;
        stall = (state != IDLE) || (req && f3_ok);
        b_word = dmem_rsp_data >> {a_q, 3'b000};
        h_word = dmem_rsp_data >> {a_q[1], 4'b0000};
        ext = (f3_q == 3'b000) ? {{24{b_word[7]}}, b_word[7:0]} :
              (f3_q == 3'b100) ? {24'b0, b_word[7:0]} :
              (f3_q == 3'b001) ? {{16{h_word[15]}}, h_word[15:0]} :
              (f3_q == 3'b101) ? {16'b0, h_word[15:0]} : dmem_rsp_data;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            f3_q <= '0;
            a_q <= '0;
            dmem_req_valid <= 1'b0;
            dmem_we <= 1'b0;
            dmem_addr <= '0;
            dmem_wdata <= '0;
            dmem_be <= '0;
            load_data <= '0;
            done <= 1'b0;
            misaligned <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            done <= 1'b0;
            misaligned <= 1'b0;
            bus_error <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    if (f3_ok && aligned) begin
                        state <= REQ;
                        cnt <= '0;
                        f3_q <= funct3;
                        a_q <= address[1:0];
                        dmem_req_valid <= 1'b1;
                        dmem_we <= mem_write;
                        dmem_addr <= {address[31:2], 2'b00};
                        dmem_wdata <= wdata_in;
                        dmem_be <= be_in;
                    end else begin
                        done <= 1'b1;
                        misaligned <= 1'b1;
                    end
                end
                REQ: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= IDLE;
                        dmem_req_valid <= 1'b0;
                        done <= 1'b1;
                        bus_error <= 1'b1;
                        load_data <= '0;
                    end else if (dmem_req_ready) begin
                        state <= WAIT;
                        dmem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (dmem_rsp_valid) begin
                        state <= IDLE;
                        done <= 1'b1;
                        if (!dmem_we) load_data <= ext;
                    end else if (cnt == LAST) begin
                        state <= IDLE;
                        done <= 1'b1;
                        bus_error <= 1'b1;
                        load_data <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
